fetch_stage: RTL
================

Name: fetch_stage

Overview:
Front-end fetch unit that drives the dual-issue instruction ROM and turns its two-word-per-clock output into a decoupled pair stream for decode. It owns the PC and compensates for the ROM's one-cycle registered read latency. It buffers fetched pairs in a small queue and handles branch/jump redirects from the back end by flushing.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
QDEPTH, 4, fetch-queue depth in instruction pairs (power of 2, >=2)
ROM_AW, 10, ROM word-address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
rom_addr  out  ROM_AW  word address to ROM (= pc[ROM_AW+1:2]), combinational from pc
rom_instr1  in  32  ROM word at rom_addr, valid one cycle after the address is sampled
rom_instr2  in  32  ROM word at rom_addr+1, same timing as rom_instr1
redirect_valid  in  1  back-end redirect/flush request
redirect_pc  in  32  redirect target byte address; bits [1:0] ignored
id_valid  out  1  queue head pair valid
id_ready  in  1  decode accepts the head pair this cycle
id_pc  out  32  byte PC of slot 0
id_instr1  out  32  slot 0 instruction
id_instr2  out  32  slot 1 instruction (PC = id_pc+4)
id_valid2  out  1  slot 1 valid

Behaviour:
- Reset (async assert): pc=RESET_PC, queue empty, inflight=0. Outputs: id_valid=0, id_valid2=0, id_pc=0, id_instr1=id_instr2=32'h0000_0013 (NOP).
- Issue: at each edge, fetch_issue = !redirect_valid && (count + inflight) < QDEPTH.
  - On issue: inflight<=1, inflight_pc<=pc, pc<=pc+8.
  - Otherwise pc holds and inflight<=0. The ROM still reads, but its data is ignored.
- Capture: at an edge with inflight=1 and no redirect, push {inflight_pc, rom_instr1, rom_instr2, v2} into the queue.
  - v2=0 when inflight_pc[ROM_AW+1:2] is all ones (the ROM's addr+1 is out of range); otherwise v2=1.
- Latency: address sampled at edge E0, data pushed at E1, id_valid high after E1. Steady-state throughput is 2 instructions/cycle.
- Handshake: the head pair is dequeued at an edge where id_valid && id_ready. Outputs are stable while id_valid && !id_ready. id_* show NOP and id_valid=0 when the queue is empty.
- Simultaneous push and pop: both occur and count is unchanged. Push into a full queue cannot happen (guaranteed by the issue gate). Pop on empty is ignored.
- Redirect (highest priority):
  - At the edge: queue cleared, inflight<=0 (in-flight ROM data discarded), pc<={redirect_pc[31:2],2'b00}.
  - A same-cycle dequeue is discarded and no push occurs.
  - Target data appears two edges later.
  - Back-to-back redirects: the last one wins.
- PC arithmetic: pc is 32-bit modulo 2^32. rom_addr wraps naturally in ROM_AW bits.
- Word-aligned but odd-word targets (pc[2]=1) are legal; pairs are not 8-byte aligned.
- Reset mid-operation: immediately returns to the reset state; the next fetch is RESET_PC.

Optional Feature:
FETCH_JAL_PREDICT_EN
- When defined: at capture, predecode slot 0 and slot 1 for opcode 7'b1101111 (JAL).
  - If slot 0 is JAL: the pushed v2 is forced to 0.
  - For the first valid JAL: target = its PC + sign-extended J-immediate. Apply an internal redirect with the same semantics as redirect_valid, but the pair being captured is still pushed.
  - External redirect_valid has priority over this internal redirect.
  - Adds output port id_pred_taken (1 bit, reset 0), meaning the head pair ends in a predicted-taken JAL.
- When undefined: strictly sequential fetch, no predecode logic, no id_pred_taken port.

Decomposition:
- Shared package (cpu_pkg): opcode localparams (OPCODE_JAL etc.), NOP constant 32'h0000_0013, fetch-pair struct/width constant {pc, instr1, instr2, v2, pred}.
- One sub-module: fetch_queue.
  - Synchronous FIFO of pairs with push/pop/flush and count.
  - Flush has priority over push/pop.

Test Plan:
- Reset release, RESET_PC=0, ROM words = index, id_ready=1:
  - id_valid rises after the 2nd edge with id_pc=0, instr1=0, instr2=1.
  - Next cycle id_pc=8, then 16, with no bubbles.
- id_ready=0 for 10 cycles from start:
  - Exactly QDEPTH=4 pairs are queued and rom_addr stalls.
  - On release, pairs drain in order 0,8,16,24, and fetch resumes at 32 with no loss or duplicates.
- Redirect to 0x0000_0104 while the queue is full and fetch is inflight:
  - Next edge id_valid=0.
  - Two edges later id_pc=0x104, instr1=ROM[65], instr2=ROM[66].
- Redirect to 0x0000_0FFC (word 1023): head pair id_valid=1, id_valid2=0; the following pair has id_pc=0x1004 (rom_addr=1).
- Assert rst for 1 cycle mid-stream: id_valid drops asynchronously and outputs return to NOP, then the sequence restarts at RESET_PC.
- With FETCH_JAL_PREDICT_EN, slot 0 at PC 0x20 is JAL with imm=+0x40:
  - Head pair shows id_valid2=0 and id_pred_taken=1.
  - The next valid pair has id_pc=0x60.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: opcode constants, the canonical NOP, the
// fetch-pair record carried from the fetch stage to decode, and a J-type
// immediate decoder used by the optional JAL predecode.
package cpu_pkg;

  localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0]  OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPCODE_OPIMM  = 7'b0010011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One fetched instruction pair as held in the fetch queue.
  typedef struct packed {
    logic [31:0] pc;      // byte PC of slot 0
    logic [31:0] instr1;  // slot 0 instruction
    logic [31:0] instr2;  // slot 1 instruction (pc + 4)
    logic        v2;      // slot 1 is valid
    logic        pred;    // pair ends in a predicted-taken JAL
  } fetch_pair_t;

  localparam int FETCH_PAIR_W = $bits(fetch_pair_t);

  // Sign-extended J-type immediate: imm[20|10:1|11|19:12] in bits 31:12.
  function automatic logic [31:0] jal_imm(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch pairs between the fetch stage and decode.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   flush            clears the queue; wins over push and pop
//   push, push_data  enqueue a pair (ignored when full)
//   pop              dequeue the head pair (ignored when empty)
//   head             pair at the head (undefined when empty)
//   empty, count     occupancy status
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_pair_t              push_data,
  input  logic                     pop,
  output fetch_pair_t              head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_pair_t   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify push/pop against occupancy.
  always_comb begin
    do_push_s = push && (count_r != FULL_CNT);
    do_pop_s  = pop && (count_r != {(AW+1){1'b0}});
  end

  // Pair storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush overrides push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign empty = (count_r == {(AW+1){1'b0}});
  assign count = count_r;

endmodule

// File: rtl/fetch_stage.sv
// Dual-issue fetch stage. Owns the PC, drives the two-word-per-clock ROM
// (one-cycle registered read), buffers fetched pairs in fetch_queue and
// flushes on back-end redirects.
// Optional feature macro: FETCH_JAL_PREDICT_EN adds JAL predecode with an
// internal redirect and the id_pred_taken output.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   rom_addr                       ROM word address (pc[ROM_AW+1:2])
//   rom_instr1, rom_instr2         ROM words at rom_addr / rom_addr+1, 1-cycle late
//   redirect_valid, redirect_pc    back-end redirect request and target
//   id_valid, id_ready             head-pair handshake with decode
//   id_pc, id_instr1, id_instr2    head pair contents
//   id_valid2                      slot 1 of head pair is valid
//   id_pred_taken                  (feature only) head pair ends in taken JAL
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4,
  parameter int          ROM_AW   = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_instr1,
  input  logic [31:0]       rom_instr2,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_instr1,
  output logic [31:0]       id_instr2,
  output logic              id_valid2
`ifdef FETCH_JAL_PREDICT_EN
  ,
  output logic              id_pred_taken
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]  pc_r;
  logic [31:0]  inflight_pc_r;
  logic         inflight_r;

  logic [CW-1:0] q_count_s;
  logic          q_empty_s;
  fetch_pair_t   q_head_s;
  fetch_pair_t   push_pair_s;
  logic [CW:0]   occupancy_s;
  logic          capture_s;
  logic          issue_s;
  logic          redir_s;
  logic [31:0]   redir_target_s;
  logic          v2_base_s;
  logic          q_pop_s;

  assign rom_addr = pc_r[ROM_AW+1:2];

  // Capture decision, pair assembly and redirect selection.
  always_comb begin
    capture_s      = inflight_r && !redirect_valid;
    // The ROM's second word comes from addr+1, which is off the end at the top word.
    v2_base_s      = !(&inflight_pc_r[ROM_AW+1:2]);
    push_pair_s.pc     = inflight_pc_r;
    push_pair_s.instr1 = rom_instr1;
    push_pair_s.instr2 = rom_instr2;
    push_pair_s.v2     = v2_base_s;
    push_pair_s.pred   = 1'b0;
    redir_s        = redirect_valid;
    redir_target_s = redirect_pc;
`ifdef FETCH_JAL_PREDICT_EN
    // External redirect already blocks capture, so it keeps priority here.
    if (capture_s && (rom_instr1[6:0] == OPCODE_JAL)) begin
      push_pair_s.v2   = 1'b0;
      push_pair_s.pred = 1'b1;
      redir_s          = 1'b1;
      redir_target_s   = inflight_pc_r + jal_imm(rom_instr1);
    end else if (capture_s && v2_base_s && (rom_instr2[6:0] == OPCODE_JAL)) begin
      push_pair_s.pred = 1'b1;
      redir_s          = 1'b1;
      redir_target_s   = inflight_pc_r + 32'd4 + jal_imm(rom_instr2);
    end else begin
      redir_s          = redirect_valid;
    end
`endif
  end

  // Issue only while every in-flight pair is guaranteed a queue slot.
  always_comb begin
    occupancy_s = {1'b0, q_count_s} + {{CW{1'b0}}, inflight_r};
    issue_s     = !redir_s && (occupancy_s < (CW+1)'(QDEPTH));
    q_pop_s     = !q_empty_s && id_ready;
  end

  // PC and in-flight tracking; a redirect discards any in-flight ROM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
    end else if (redir_s) begin
      pc_r          <= {redir_target_s[31:2], 2'b00};
      inflight_r    <= 1'b0;
    end else if (issue_s) begin
      pc_r          <= pc_r + 32'd8;
      inflight_r    <= 1'b1;
      inflight_pc_r <= pc_r;
    end else begin
      inflight_r    <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (capture_s),
    .push_data (push_pair_s),
    .pop       (q_pop_s),
    .head      (q_head_s),
    .empty     (q_empty_s),
    .count     (q_count_s)
  );

`ifndef FETCH_JAL_PREDICT_EN
  logic unused_pred_s;
  assign unused_pred_s = q_head_s.pred;
`endif

  // Present the head pair to decode, NOPs when the queue is empty.
  always_comb begin
    if (q_empty_s) begin
      id_valid      = 1'b0;
      id_valid2     = 1'b0;
      id_pc         = 32'h0000_0000;
      id_instr1     = NOP_INSTR;
      id_instr2     = NOP_INSTR;
`ifdef FETCH_JAL_PREDICT_EN
      id_pred_taken = 1'b0;
`endif
    end else begin
      id_valid      = 1'b1;
      id_valid2     = q_head_s.v2;
      id_pc         = q_head_s.pc;
      id_instr1     = q_head_s.instr1;
      id_instr2     = q_head_s.instr2;
`ifdef FETCH_JAL_PREDICT_EN
      id_pred_taken = q_head_s.pred;
`endif
    end
  end

endmodule
